// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 output display.
// Holds the 4-bit digit codes, the active-low 7-segment patterns, the
// conversion FSM state type, and helpers for the double-dabble datapath.
// Segment patterns are ordered {g,f,e,d,c,b,a}, and a 0 lights a segment.
package sap1_pkg;

  // Digit codes. Codes 0-9 are plain BCD. Two extra codes give a blank digit and a minus.
  localparam logic [3:0] DIG_ZERO  = 4'h0;
  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_MINUS = 4'hB;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // One conversion request: the unsigned magnitude plus the sign to show.
  typedef struct packed {
    logic       neg;
    logic [7:0] mag;
  } conv_req_t;

  // Builds a request from a raw output-register value.
  // A negative input has a magnitude of at most 128, so 8 bits hold it.
  function automatic conv_req_t make_req(input logic [7:0] value, input logic signed_mode);
    conv_req_t  req;
    logic [8:0] neg_mag;
    neg_mag = {1'b0, ~value} + 9'd1;
    req.neg = signed_mode && value[7];
    req.mag = req.neg ? neg_mag[7:0] : value;
    return req;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  // This runs before each left shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational decoder from a 4-bit digit code to active-low segments.
// Ports:
//   i_digit  in  4  digit code: 0-9, DIG_BLANK or DIG_MINUS
//   o_seg    out 7  segments {g,f,e,d,c,b,a}, active-low
// Codes C-F are not used, so they decode to blank.
module seg_decoder
  import sap1_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: give every always_comb output a default before the case.
    // Without it, any path that misses an assignment infers a latch.
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:      o_seg = SEG_0;
      4'd1:      o_seg = SEG_1;
      4'd2:      o_seg = SEG_2;
      4'd3:      o_seg = SEG_3;
      4'd4:      o_seg = SEG_4;
      4'd5:      o_seg = SEG_5;
      4'd6:      o_seg = SEG_6;
      4'd7:      o_seg = SEG_7;
      4'd8:      o_seg = SEG_8;
      4'd9:      o_seg = SEG_9;
      DIG_MINUS: o_seg = SEG_MINUS;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/out_display.sv
// Decimal display for the SAP-1 output register.
// A sequential double-dabble engine converts each loaded value to BCD.
// The result drives a time-multiplexed 4-digit common-anode 7-segment display,
// laid out as [sign][hundreds][tens][ones].
// Ports:
//   clk_i    in  1  system clock
//   rstn_i   in  1  asynchronous reset, active-low
//   value_i  in  8  output-register value
//   ld_i     in  1  output register loaded; request a conversion
//   busy_o   out 1  conversion in progress
//   seg_o    out 7  segments {g,f,e,d,c,b,a}, active-low
//   an_o     out 4  digit enables, active-low one-hot; an_o[0] is the ones digit
//   dp_o     out 1  decimal point, active-low, always off
module out_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] value_i,
  input  logic       ld_i,
  output logic       busy_o,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       dp_o
);
  import sap1_pkg::*;

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Conversion engine state
  state_t      r_state;
  logic        r_busy;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_shift_cnt;
  logic        r_neg;
  conv_req_t   r_pend;
  logic        r_pending;
  logic [3:0]  r_digit [4];

  // Scan state
  logic [CNT_W-1:0] r_refresh_cnt;
  logic [1:0]       r_scan_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  conv_req_t   w_req_in;
  conv_req_t   w_start_req;
  logic [11:0] w_bcd_adj;
  logic [3:0]  w_digit_next [4];
  logic [6:0]  w_seg_dec;

  assign w_req_in  = make_req(value_i, SIGNED_MODE);
  assign w_bcd_adj = dd_adjust(r_bcd);

  // A conversion takes a fresh ld_i only from IDLE.
  // Every other start (IDLE with pending, or the LATCH re-arm) uses the pending request.
  assign w_start_req = (r_state == IDLE && ld_i) ? w_req_in : r_pend;

  // Leading-zero blanking. Tens stays visible when hundreds is non-zero.
  always_comb begin
    w_digit_next[0] = r_bcd[3:0];
    w_digit_next[1] = (r_bcd[11:8] == 4'd0 && r_bcd[7:4] == 4'd0) ? DIG_BLANK : r_bcd[7:4];
    w_digit_next[2] = (r_bcd[11:8] == 4'd0) ? DIG_BLANK : r_bcd[11:8];
    w_digit_next[3] = r_neg ? DIG_MINUS : DIG_BLANK;
  end

  // NOTE: all sequential state uses non-blocking assignments.
  // Each register then updates from values sampled at the same edge,
  // whatever order the statements appear in.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_shift_cnt <= '0;
      r_neg       <= 1'b0;
      r_pend      <= '0;
      r_pending   <= 1'b0;
      r_digit[0]  <= DIG_ZERO;
      r_digit[1]  <= DIG_BLANK;
      r_digit[2]  <= DIG_BLANK;
      r_digit[3]  <= DIG_BLANK;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_i || r_pending) begin
            r_state     <= SHIFT;
            r_busy      <= 1'b1;
            r_bin       <= w_start_req.mag;
            r_neg       <= w_start_req.neg;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_pending   <= 1'b0;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
          r_shift_cnt    <= r_shift_cnt + 3'd1;
          if (r_shift_cnt == 3'd7) r_state <= LATCH;
        end
        LATCH: begin
          r_digit <= w_digit_next;
          if (r_pending) begin
            r_state     <= SHIFT;
            r_bin       <= w_start_req.mag;
            r_neg       <= w_start_req.neg;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_pending   <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A request while busy is parked, and the last one wins.
      // This comes after the case so it overrides the pending clear in a LATCH re-arm.
      if (ld_i && r_state != IDLE) begin
        r_pend    <= w_req_in;
        r_pending <= 1'b1;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .i_digit (r_digit[r_scan_idx]),
    .o_seg   (w_seg_dec)
  );

  // The scan free-runs, independent of the conversion FSM.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
      r_an          <= 4'b1110;
      r_seg         <= SEG_0;
    end else begin
      if (r_refresh_cnt == CNT_MAX) begin
        r_refresh_cnt <= '0;
        r_scan_idx    <= r_scan_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_scan_idx);
      r_seg <= w_seg_dec;
    end
  end

  assign busy_o = r_busy;
  assign seg_o  = r_seg;
  assign an_o   = r_an;
  assign dp_o   = 1'b1;

endmodule

// File: tb/tb_out_display.sv
// Testbench for out_display.
// An unsigned instance and a signed instance share the clock, the reset and value_i.
// Each instance has its own ld input.
// Stimulus pushes the expected display frame for every conversion that should complete.
// For each instance, a monitor counts busy cycles. Every 9th contiguous busy cycle
// marks a completed conversion. The monitor then captures the scanned digits and
// compares them with the frame at the head of the queue.
`timescale 1ns/1ps
module tb_out_display;

  typedef logic [27:0] frame_t;  // four 7-bit patterns; position p at [7*p +: 7]

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] value;
  logic       ld_u, ld_s;
  logic       busy_u, busy_s, dp_u, dp_s;
  logic [6:0] seg_u, seg_s;
  logic [3:0] an_u, an_s;

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  out_display #(.REFRESH_DIV(4), .SIGNED_MODE(1'b0)) u_dut_u (
    .clk_i(clk), .rstn_i(rstn), .value_i(value), .ld_i(ld_u),
    .busy_o(busy_u), .seg_o(seg_u), .an_o(an_u), .dp_o(dp_u));

  out_display #(.REFRESH_DIV(4), .SIGNED_MODE(1'b1)) u_dut_s (
    .clk_i(clk), .rstn_i(rstn), .value_i(value), .ld_i(ld_s),
    .busy_o(busy_s), .seg_o(seg_s), .an_o(an_s), .dp_o(dp_s));

  // Hand-written active-low patterns; 10 = blank, 11 = minus
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  11: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic frame_t fr(input int d3, input int d2, input int d1, input int d0);
    return {pat(d3), pat(d2), pat(d1), pat(d0)};
  endfunction

  function automatic int an_pos(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_frame(input int k, input frame_t cap, input logic [3:0] got);
    frame_t e;
    bit     ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL frame dut%0d: unexpected frame %h (positions %b), none expected", k, cap, got);
    end else begin
      e  = exp_q.pop_front();
      ok = ($countones(got) >= 2);
      for (int p = 0; p < 4; p++)
        if (got[p] && cap[7*p +: 7] !== e[7*p +: 7]) ok = 1'b0;
      if (!ok) begin
        n_fail++;
        $display("FAIL frame dut%0d: got %h (positions %b), expected %h", k, cap, got, e);
      end
    end
  endtask

  task automatic monitor(input int k);
    int         run = 0, cd = 0, nsamp = 0, p;
    bit         active = 1'b0;
    frame_t     cap = '0;
    logic [3:0] got = '0;
    logic       b;
    logic [6:0] s;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      b = (k == 0) ? busy_u : busy_s;
      s = (k == 0) ? seg_u : seg_s;
      a = (k == 0) ? an_u : an_s;
      if (!rstn) begin
        run = 0; cd = 0; active = 1'b0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (active) finish_frame(k, cap, got);
          active = 1'b1; nsamp = 0; got = '0; cap = '0;
        end
      end
      if (active) begin
        p = an_pos(a);
        if (p < 0) begin
          n_checks++; n_fail++;
          $display("FAIL an_onehot dut%0d: got %b, expected one-hot low", k, a);
        end else begin
          cap[7*p +: 7] = s;
          got[p] = 1'b1;
        end
        nsamp++;
        if (nsamp == 16) begin
          finish_frame(k, cap, got);
          active = 1'b0;
        end
      end
      if (b) begin
        run++;
        if (run % 9 == 0) cd = 2;  // new digits reach seg_o two cycles after LATCH
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic pulse_ld(input int k, input logic [7:0] v);
    @(negedge clk);
    value = v;
    if (k == 0) ld_u = 1'b1; else ld_s = 1'b1;
    @(negedge clk);
    ld_u = 1'b0; ld_s = 1'b0;
  endtask

  // Called in busy cycle 1; counts busy cycles until busy drops (bounded)
  task automatic count_busy(input int k, output int n);
    n = 0;
    while (((k == 0) ? busy_u : busy_s) && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic convert(input int k, input logic [7:0] v, input frame_t e);
    int n;
    exp_q.push_back(e);
    pulse_ld(k, v);
    count_busy(k, n);
    check($sformatf("busy_len dut%0d v=%0h", k, v), n, 9);
    repeat (24) @(negedge clk);
  endtask

  initial fork
    monitor(0);
    monitor(1);
  join_none

  initial begin
    int         n, cyc;
    logic [3:0] a0;
    frame_t     cap;

    rstn = 1'b0; value = '0; ld_u = 1'b0; ld_s = 1'b0;

    // 1: reset state, then held after release
    repeat (3) @(negedge clk);
    check("rst an", an_u, 4'b1110);
    check("rst seg", seg_u, 7'b1000000);
    check("rst busy", busy_u, 0);
    check("rst dp", dp_u, 1);
    check("rst an signed", an_s, 4'b1110);
    rstn = 1'b1;
    @(negedge clk);
    check("rel an", an_u, 4'b1110);
    check("rel seg", seg_u, 7'b1000000);
    check("rel busy", busy_u, 0);

    // 2: 255, 9 busy cycles, 4-cycle digit dwell
    convert(0, 8'd255, fr(10, 2, 5, 5));
    a0 = an_u; n = 0;
    while (an_u == a0 && n < 10) begin n++; @(negedge clk); end
    a0 = an_u; n = 1;
    @(negedge clk);
    while (an_u == a0 && n < 10) begin n++; @(negedge clk); end
    check("digit dwell", n, 4);

    // 3: blanking and boundaries, unsigned
    convert(0, 8'd7,   fr(10, 10, 10, 7));
    convert(0, 8'd100, fr(10, 1, 0, 0));
    convert(0, 8'd10,  fr(10, 10, 1, 0));
    convert(0, 8'd105, fr(10, 1, 0, 5));
    convert(0, 8'hF6,  fr(10, 2, 4, 6));
    convert(0, 8'd0,   fr(10, 10, 10, 0));

    // 4: signed instance
    convert(1, 8'hF6, fr(11, 10, 1, 0));
    convert(1, 8'h80, fr(11, 1, 2, 8));
    convert(1, 8'h05, fr(10, 10, 10, 5));

    // 5: 100, then 42 at busy cycle 3, then 43 at busy cycle 5; 42 is never shown
    exp_q.push_back(fr(10, 1, 0, 0));
    exp_q.push_back(fr(10, 10, 4, 3));
    @(negedge clk); value = 8'd100; ld_u = 1'b1;
    @(negedge clk); ld_u = 1'b0;
    n = 0; cyc = 1;
    while (busy_u && cyc < 80) begin
      n++;
      @(negedge clk);
      cyc++;
      ld_u = (cyc == 3 || cyc == 5);
      if (cyc == 3) value = 8'd42;
      if (cyc == 5) value = 8'd43;
    end
    ld_u = 1'b0;
    check("pending busy_len", n, 18);
    repeat (24) @(negedge clk);

    // ld_i held for three cycles: one conversion plus one pending
    exp_q.push_back(fr(10, 10, 10, 9));
    exp_q.push_back(fr(10, 10, 10, 9));
    @(negedge clk); value = 8'd9; ld_u = 1'b1;
    n = 0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (c == 3) ld_u = 1'b0;
      if (busy_u) n++;
      else if (n > 0) break;
    end
    check("held ld busy_len", n, 18);
    repeat (24) @(negedge clk);

    // 6: reset at busy cycle 4 of 200, with a pending 50 that must be discarded
    pulse_ld(0, 8'd200);                       // now in busy cycle 1
    value = 8'd50; ld_u = 1'b1;                // sampled at the end of busy cycle 1
    @(negedge clk); ld_u = 1'b0;               // busy cycle 2
    repeat (2) @(negedge clk);                 // busy cycle 4
    rstn = 1'b0;
    #1;
    check("abort busy", busy_u, 0);
    check("abort an", an_u, 4'b1110);
    check("abort seg", seg_u, 7'b1000000);
    @(negedge clk); rstn = 1'b1;
    n = 0; cap = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy_u) n++;
      if (an_pos(an_u) >= 0) cap[7*an_pos(an_u) +: 7] = seg_u;
    end
    check("post-reset busy cycles", n, 0);
    check("post-reset frame", cap, fr(10, 10, 10, 0));

    check("queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
